// File: rtl/fetch_pkg.sv
// Shared widths, constants and the IF/ID payload type for the fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W_DEF = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: loads when empty or drained, flushes on redirect, holds on stall.
module fetch_if_id_reg
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            ready,
    input  logic [XLEN-1:0] fetch_instr,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            load_en_c,
    output if_id_t          if_id
);

    if_id_t if_id_d;

    // Next-state: flush beats load, load beats hold.
    always_comb begin
        if_id_d   = if_id;
        load_en_c = !if_id.valid || ready;
        if (flush) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (load_en_c) begin
            if_id_d.valid    = 1'b1;
            if_id_d.instr    = fetch_instr;
            if_id_d.pc       = fetch_pc;
            if_id_d.pc_plus4 = fetch_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0};
        end else begin
            if_id <= if_id_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC mux, handoff counter and IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_pc_plus4,
    output logic [CNT_W-1:0] instr_count
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic             misalign_trap,
    output logic [XLEN-1:0]  trap_addr
`endif
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            load_en_c;
    logic            trap_d;
    if_id_t          if_id;

    fetch_if_id_reg u_if_id (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect_valid),
        .ready       (id_ready),
        .fetch_instr (imem_rdata),
        .fetch_pc    (pc_q),
        .load_en_c   (load_en_c),
        .if_id       (if_id)
    );

    assign imem_addr   = pc_q;
    assign id_valid    = if_id.valid;
    assign id_instr    = if_id.instr;
    assign id_pc       = if_id.pc;
    assign id_pc_plus4 = if_id.pc_plus4;

    // Next PC: redirect first, then sequential advance whenever IF/ID accepts a word.
    always_comb begin
        pc_d   = pc_q;
        trap_d = 1'b0;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                trap_d = 1'b1;
            end else begin
                pc_d = redirect_pc;
            end
`else
            pc_d = redirect_pc & ALIGN_MASK;
`endif
        end else if (load_en_c) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            instr_count <= '0;
        end else begin
            pc_q <= pc_d;
            if (id_valid && id_ready) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Single-cycle trap pulse; the faulting target stays visible until the next trap.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_trap <= 1'b0;
            trap_addr     <= '0;
        end else begin
            misalign_trap <= trap_d;
            if (trap_d) begin
                trap_addr <= redirect_pc;
            end
        end
    end
`else
    logic unused_trap;
    assign unused_trap = trap_d;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, wrap instance, and random run against a model.
// Honours FETCH_MISALIGN_TRAP_EN the same way as the design.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_pc_plus4, instr_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic [31:0] trap_addr;
    logic        w_trap;
    logic [31:0] w_taddr;
`endif

    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4, w_cnt;
    logic        w_valid;

    int tests = 0;
    int fails = 0;

    assign imem_rdata = imem_addr >> 2;
    assign w_rdata    = w_addr >> 2;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .instr_count    (instr_count)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap  (misalign_trap),
        .trap_addr      (trap_addr)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .id_ready       (1'b1),
        .id_valid       (w_valid),
        .id_instr       (w_instr),
        .id_pc          (w_pc),
        .id_pc_plus4    (w_pc4),
        .instr_count    (w_cnt)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap  (w_trap),
        .trap_addr      (w_taddr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the stage should present after each edge.
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_cnt, m_taddr;
    logic        m_valid, m_trap;

    task automatic model_step(input logic rst, input logic rv, input logic [31:0] rp,
                              input logic rdy);
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP_INSTR; m_idpc = 32'h0;
            m_idpc4 = 32'h0; m_cnt = 32'h0; m_trap = 1'b0; m_taddr = 32'h0;
        end else begin
            if (m_valid && rdy) m_cnt = m_cnt + 1;
            m_trap = 1'b0;
            if (rv) begin
                m_valid = 1'b0;
                m_instr = NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (rp % 4 != 0) begin
                    m_trap  = 1'b1;
                    m_taddr = rp;
                end else begin
                    m_pc = rp;
                end
`else
                m_pc = rp - (rp % 4);
`endif
            end else if (!m_valid || rdy) begin
                m_instr = m_pc / 4;
                m_idpc  = m_pc;
                m_idpc4 = m_pc + 4;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic rv, input logic [31:0] rp,
                        input logic rdy);
        @(negedge clk);
        reset = rst; redirect_valid = rv; redirect_pc = rp; id_ready = rdy;
        @(posedge clk);
        model_step(rst, rv, rp, rdy);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rp;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [31:0] e_cnt;
        logic        e_trap;
        logic [31:0] e_taddr;
        logic        pc_chk;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rv, input logic [31:0] rp,
                                input logic rdy, input logic ev, input logic [31:0] ei,
                                input logic [31:0] ep, input logic [31:0] ea,
                                input logic [31:0] ec, input logic et,
                                input logic [31:0] eta, input logic pcc);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rp = rp; v.rdy = rdy; v.e_valid = ev; v.e_instr = ei;
        v.e_pc = ep; v.e_addr = ea; v.e_cnt = ec; v.e_trap = et; v.e_taddr = eta;
        v.pc_chk = pcc;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;

        vecs[0]  = mk(1, 0, 32'h0,  1, 0, NOP_INSTR, 32'h0,  32'h0,  0, 0, 32'h0, 1);
        vecs[1]  = mk(0, 0, 32'h0,  1, 1, 32'h0,     32'h0,  32'h4,  0, 0, 32'h0, 1);
        vecs[2]  = mk(0, 0, 32'h0,  1, 1, 32'h1,     32'h4,  32'h8,  1, 0, 32'h0, 1);
        vecs[3]  = mk(0, 0, 32'h0,  1, 1, 32'h2,     32'h8,  32'hC,  2, 0, 32'h0, 1);
        vecs[4]  = mk(0, 0, 32'h0,  0, 1, 32'h2,     32'h8,  32'hC,  2, 0, 32'h0, 1);
        vecs[5]  = mk(0, 0, 32'h0,  0, 1, 32'h2,     32'h8,  32'hC,  2, 0, 32'h0, 1);
        vecs[6]  = mk(0, 0, 32'h0,  0, 1, 32'h2,     32'h8,  32'hC,  2, 0, 32'h0, 1);
        vecs[7]  = mk(0, 0, 32'h0,  1, 1, 32'h3,     32'hC,  32'h10, 3, 0, 32'h0, 1);
        vecs[8]  = mk(0, 0, 32'h0,  0, 1, 32'h3,     32'hC,  32'h10, 3, 0, 32'h0, 1);
        vecs[9]  = mk(0, 1, 32'h40, 0, 0, NOP_INSTR, 32'hC,  32'h40, 3, 0, 32'h0, 0);
        vecs[10] = mk(0, 0, 32'h0,  1, 1, 32'h10,    32'h40, 32'h44, 3, 0, 32'h0, 1);
        vecs[11] = mk(0, 0, 32'h0,  1, 1, 32'h11,    32'h44, 32'h48, 4, 0, 32'h0, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[12] = mk(0, 1, 32'h42, 1, 0, NOP_INSTR, 32'h44, 32'h48, 5, 1, 32'h42, 0);
        vecs[13] = mk(0, 0, 32'h0,  1, 1, 32'h12,    32'h48, 32'h4C, 5, 0, 32'h42, 1);
`else
        vecs[12] = mk(0, 1, 32'h42, 1, 0, NOP_INSTR, 32'h44, 32'h40, 5, 0, 32'h0, 0);
        vecs[13] = mk(0, 0, 32'h0,  1, 1, 32'h10,    32'h40, 32'h44, 5, 0, 32'h0, 1);
`endif
        vecs[14] = mk(1, 1, 32'h80, 0, 0, NOP_INSTR, 32'h0,  32'h0,  0, 0, 32'h0, 1);
        vecs[15] = mk(0, 0, 32'h0,  1, 1, 32'h0,     32'h0,  32'h4,  0, 0, 32'h0, 1);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].rv, vecs[i].rp, vecs[i].rdy);
            chk($sformatf("vec%0d id_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d id_instr", i), id_instr, vecs[i].e_instr);
            chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d instr_count", i), instr_count, vecs[i].e_cnt);
            if (vecs[i].pc_chk) begin
                chk($sformatf("vec%0d id_pc", i), id_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d id_pc_plus4", i), id_pc_plus4,
                    vecs[i].rst ? 32'h0 : vecs[i].e_pc + 32'h4);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            chk($sformatf("vec%0d misalign_trap", i), 32'(misalign_trap), 32'(vecs[i].e_trap));
            chk($sformatf("vec%0d trap_addr", i), trap_addr, vecs[i].e_taddr);
`endif
            // Wrap instance shares reset and always accepts.
            if (i == 1) begin
                chk("wrap first id_valid", 32'(w_valid), 32'h1);
                chk("wrap first id_pc", w_pc, 32'hFFFF_FFFC);
                chk("wrap first id_pc_plus4", w_pc4, 32'h0);
                chk("wrap imem_addr", w_addr, 32'h0);
            end
            if (i == 2) begin
                chk("wrap second id_pc", w_pc, 32'h0);
                chk("wrap second id_pc_plus4", w_pc4, 32'h4);
            end
        end

        // Random run against the reference model.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int n = 0; n < 1500; n++) begin
            logic        rst, rv, rdy;
            logic [31:0] rp;
            rst = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rp  = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                               : ($urandom & 32'h0000_0FFF);
            step(rst, rv, rp, rdy);
            chk("rand id_valid", 32'(id_valid), 32'(m_valid));
            chk("rand id_instr", id_instr, m_instr);
            chk("rand imem_addr", imem_addr, m_pc);
            chk("rand instr_count", instr_count, m_cnt);
            if (m_valid) begin
                chk("rand id_pc", id_pc, m_idpc);
                chk("rand id_pc_plus4", id_pc_plus4, m_idpc4);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("rand misalign_trap", 32'(misalign_trap), 32'(m_trap));
            chk("rand trap_addr", trap_addr, m_taddr);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
